// File: rtl/vga_frame_scanner.sv
// vga_frame_scanner: scans a whole-frame matrix out as VGA timing plus pixel data.
// Define VGA_DOUBLE_BUFFER_EN to add a shadow buffer that swaps in at the frame boundary.
module vga_frame_scanner #(
    parameter int IMAGE_BITS = 8,
    parameter int MATRIX_N   = 160,
    parameter int MATRIX_M   = 120,
    parameter int SCALE_LOG2 = 2,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33
) (
    input  logic                                     Clk,
    input  logic                                     Reset,
    input  logic [IMAGE_BITS*MATRIX_N*MATRIX_M-1:0]  ImgMat,
    input  logic                                     ReqIn,
    output logic                                     AckIn,
    output logic [IMAGE_BITS-1:0]                    Pixel,
    output logic                                     HSync,
    output logic                                     VSync,
    output logic                                     Active,
    output logic                                     FrameStart,
    output logic                                     Pending
);

    localparam int FLAT_WIDE = IMAGE_BITS * MATRIX_N * MATRIX_M;
    localparam int H_ACTIVE  = MATRIX_N << SCALE_LOG2;
    localparam int V_ACTIVE  = MATRIX_M << SCALE_LOG2;
    localparam int H_TOTAL   = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL   = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW        = $clog2(H_TOTAL + 1);
    localparam int VW        = $clog2(V_TOTAL + 1);
    localparam int IDX_W     = $clog2(FLAT_WIDE);

    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SLO  = HW'(H_ACTIVE + H_FRONT);
    localparam logic [HW-1:0] H_SHI  = HW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SLO  = VW'(V_ACTIVE + V_FRONT);
    localparam logic [VW-1:0] V_SHI  = VW'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    logic [HW-1:0]         r_hcnt;
    logic [VW-1:0]         r_vcnt;
    logic [FLAT_WIDE-1:0]  r_display;
    logic [IMAGE_BITS-1:0] r_pixel;
    logic                  r_hsync;
    logic                  r_vsync;
    logic                  r_active;
    logic                  r_frame_start;
    logic                  r_ack;

    logic                  w_h_last;
    logic                  w_v_last;
    logic                  w_active;
    logic                  w_hsync_n;
    logic                  w_vsync_n;
    logic                  w_first;
    logic                  w_capture;
    logic [IDX_W-1:0]      w_bit_idx;
    logic [IMAGE_BITS-1:0] w_pixel;

    always_comb begin
        w_h_last  = (r_hcnt == H_LAST);
        w_v_last  = (r_vcnt == V_LAST);
        w_active  = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
        w_hsync_n = !((r_hcnt >= H_SLO) && (r_hcnt < H_SHI));
        w_vsync_n = !((r_vcnt >= V_SLO) && (r_vcnt < V_SHI));
        w_first   = (r_hcnt == '0) && (r_vcnt == '0);
        // Replication is just dropping the low SCALE_LOG2 bits of each counter
        w_bit_idx = IDX_W'((((int'(r_vcnt) >> SCALE_LOG2) * MATRIX_N)
                          + (int'(r_hcnt) >> SCALE_LOG2)) * IMAGE_BITS);
        w_pixel   = '0;
        if (w_active)
            w_pixel = r_display[w_bit_idx +: IMAGE_BITS];
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_hcnt        <= '0;
            r_vcnt        <= '0;
            r_pixel       <= '0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_active      <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_pixel       <= w_pixel;
            r_hsync       <= w_hsync_n;
            r_vsync       <= w_vsync_n;
            r_active      <= w_active;
            r_frame_start <= w_first;
            if (w_h_last) begin
                r_hcnt <= '0;
                r_vcnt <= w_v_last ? '0 : r_vcnt + 1'b1;
            end else begin
                r_hcnt <= r_hcnt + 1'b1;
            end
        end
    end

`ifdef VGA_DOUBLE_BUFFER_EN
    logic [FLAT_WIDE-1:0] r_shadow;
    logic                 r_pending;
    logic                 w_swap;

    // Capture is blocked while pending, so a swap can never coincide with it
    always_comb begin
        w_swap    = w_h_last & w_v_last & r_pending;
        w_capture = ReqIn & ~r_pending & ~r_ack;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_shadow  <= '0;
            r_display <= '0;
            r_pending <= 1'b0;
            r_ack     <= 1'b0;
        end else begin
            r_ack <= w_capture;
            if (w_capture)
                r_shadow <= ImgMat;
            if (w_swap)
                r_display <= r_shadow;
            if (w_swap)
                r_pending <= 1'b0;
            else if (w_capture)
                r_pending <= 1'b1;
        end
    end

    assign Pending = r_pending;
`else
    // Writing only during vertical blank keeps the visible frame intact
    always_comb begin
        w_capture = ReqIn & ~r_ack & (r_vcnt >= V_ACT);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_display <= '0;
            r_ack     <= 1'b0;
        end else begin
            r_ack <= w_capture;
            if (w_capture)
                r_display <= ImgMat;
        end
    end

    assign Pending = 1'b0;
`endif

    assign AckIn      = r_ack;
    assign Pixel      = r_pixel;
    assign HSync      = r_hsync;
    assign VSync      = r_vsync;
    assign Active     = r_active;
    assign FrameStart = r_frame_start;

endmodule

// File: tb/tb_vga_frame_scanner.sv
// tb_vga_frame_scanner: scoreboard bench on a reduced 4x3 matrix, 2x scale,
// 15-clock lines and 10-line frames (150 clocks per frame).
module tb_vga_frame_scanner;

    localparam int IB = 8;
    localparam int MN = 4;
    localparam int MM = 3;
    localparam int SL = 1;
    localparam int FW = IB * MN * MM;
    localparam int HT = 15;
    localparam int VT = 10;
    localparam int FT = 150;

`ifdef VGA_DOUBLE_BUFFER_EN
    localparam int   ACK_A = 169;
    localparam int   ACK_B = 301;
    localparam int   ACK_C = 451;
    localparam int   REQ_B = 200;
    localparam int   IMG_F4 = 3;
    localparam logic DB = 1'b1;
`else
    localparam int   ACK_A = 241;
    localparam int   ACK_B = 421;
    localparam int   ACK_C = -1;
    localparam int   REQ_B = 420;
    localparam int   IMG_F4 = 2;
    localparam logic DB = 1'b0;
`endif

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic          ReqIn = 1'b0;
    logic [FW-1:0] ImgMat = '0;
    logic          AckIn;
    logic [IB-1:0] Pixel;
    logic          HSync;
    logic          VSync;
    logic          Active;
    logic          FrameStart;
    logic          Pending;

    vga_frame_scanner #(
        .IMAGE_BITS (IB),
        .MATRIX_N   (MN),
        .MATRIX_M   (MM),
        .SCALE_LOG2 (SL),
        .H_FRONT    (2),
        .H_SYNC     (3),
        .H_BACK     (2),
        .V_FRONT    (1),
        .V_SYNC     (2),
        .V_BACK     (1)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .ImgMat     (ImgMat),
        .ReqIn      (ReqIn),
        .AckIn      (AckIn),
        .Pixel      (Pixel),
        .HSync      (HSync),
        .VSync      (VSync),
        .Active     (Active),
        .FrameStart (FrameStart),
        .Pending    (Pending)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int         at;
        string      nm;
        logic [7:0] pix;
        logic       hs, vs, act, fs, ack, pend;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   n_vec = 0;
    int   n_bad = 0;
    int   edges;

    // Edge k after reset release presents position k; sampled when edges == k+1
    always @(posedge Clk or negedge Reset)
        if (!Reset) edges <= 0;
        else        edges <= edges + 1;

    always @(negedge Clk) begin
        while (sb.size() > 0 && sb[0].at <= edges) begin
            e_mon = sb.pop_front();
            n_vec++;
            if (e_mon.at < edges) begin
                n_bad++;
                $display("FAIL %s at=%0d: never sampled, now at %0d",
                         e_mon.nm, e_mon.at, edges);
            end else if ({Pixel, HSync, VSync, Active, FrameStart, AckIn, Pending} !==
                         {e_mon.pix, e_mon.hs, e_mon.vs, e_mon.act,
                          e_mon.fs, e_mon.ack, e_mon.pend}) begin
                n_bad++;
                $display("FAIL %s at=%0d: got pix=%h hs=%b vs=%b act=%b fs=%b ack=%b pend=%b, want pix=%h hs=%b vs=%b act=%b fs=%b ack=%b pend=%b",
                         e_mon.nm, e_mon.at, Pixel, HSync, VSync, Active,
                         FrameStart, AckIn, Pending, e_mon.pix, e_mon.hs,
                         e_mon.vs, e_mon.act, e_mon.fs, e_mon.ack, e_mon.pend);
            end
        end
    end

    function automatic logic [7:0] elem(int id, int x, int y);
        case (id)
            1:       return 8'((x + y) & 255);
            2:       return 8'(8'h80 | (y << 4) | x);
            3:       return 8'(8'h20 + 4 * y + x);
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [FW-1:0] frame_of(int id);
        logic [FW-1:0] f;
        f = '0;
        for (int y = 0; y < MM; y++)
            for (int x = 0; x < MN; x++)
                f[(y * MN + x) * IB +: IB] = elem(id, x, y);
        return f;
    endfunction

    function automatic int img_of(int frame);
        if (frame < 2) return 0;
        if (frame == 2) return 1;
        if (frame == 3) return 2;
        return IMG_F4;
    endfunction

    function automatic logic pend_of(int at);
        if (!DB) return 1'b0;
        return (at >= 169 && at < 300) || (at >= 301 && at < 450) ||
               (at >= 451 && at < 600);
    endfunction

    task automatic push_pos(int k, int id, logic ack, logic pend);
        exp_t e;
        int h, v;
        h = k % HT;
        v = (k / HT) % VT;
        e.at   = k + 1;
        e.nm   = "scan";
        e.act  = (h < 8) && (v < 6);
        e.hs   = !(h >= 10 && h < 13);
        e.vs   = !(v >= 7 && v < 9);
        e.fs   = (h == 0) && (v == 0);
        e.pix  = e.act ? elem(id, h / 2, v / 2) : 8'h00;
        e.ack  = ack;
        e.pend = pend;
        sb.push_back(e);
    endtask

    task automatic push_one(int at, string nm, logic [7:0] pix, logic hs,
                            logic vs, logic act, logic fs, logic pend);
        exp_t e;
        e.at = at; e.nm = nm; e.pix = pix; e.hs = hs; e.vs = vs;
        e.act = act; e.fs = fs; e.ack = 1'b0; e.pend = pend;
        sb.push_back(e);
    endtask

    task automatic push_hand(int at);
        case (at)
            1:   push_one(at, "first_fs", 8'h00, 1, 1, 1, 1, 0);
            11:  push_one(at, "hsync_lo", 8'h00, 0, 1, 0, 0, 0);
            109: push_one(at, "vsync_lo", 8'h00, 1, 0, 0, 0, 0);
            335: push_one(at, "imgA_2_1", 8'h03, 1, 1, 1, 0, DB);
            532: push_one(at, "imgB_3_2", 8'hA3, 1, 1, 1, 0, DB);
            default: ;
        endcase
    endtask

    task automatic at_neg(int n);
        while (edges != n) @(negedge Clk);
    endtask

    task automatic push_frame(int f);
        int at;
        for (int k = f * FT; k < f * FT + FT && k < 665; k++) begin
            at = k + 1;
            push_pos(k, img_of(f),
                     (at == ACK_A) || (at == ACK_B) || (at == ACK_C),
                     pend_of(at));
            push_hand(at);
        end
    endtask

    initial begin
        push_one(0, "reset", 8'h00, 1, 1, 0, 0, 0);
        #22 Reset = 1'b1;
        fork
            begin
                for (int f = 0; f < 5; f++) begin
                    at_neg(f * FT);
                    push_frame(f);
                end
            end
            begin
                ImgMat = frame_of(1);
                at_neg(168); ReqIn = 1'b1;
                at_neg(ACK_A); ReqIn = 1'b0;
                ImgMat = frame_of(2);
                at_neg(REQ_B); ReqIn = 1'b1;
                at_neg(ACK_B); ReqIn = 1'b0;
                if (DB) begin
                    ImgMat = frame_of(3);
                    at_neg(449); ReqIn = 1'b1;
                    at_neg(ACK_C); ReqIn = 1'b0;
                end
            end
        join

        // Mid-line reset with the counters at h=6, v=4 inside the active area
        at_neg(665);
        @(posedge Clk);
        #2 Reset = 1'b0;
        #1 push_one(0, "async_rst", 8'h00, 1, 1, 0, 0, 0);
        repeat (3) @(negedge Clk);
        for (int k = 0; k < 30; k++) begin
            push_pos(k, 0, 1'b0, 1'b0);
            if (k == 0) push_one(1, "rst_fs", 8'h00, 1, 1, 1, 1, 0);
        end
        #2 Reset = 1'b1;
        at_neg(31);
        @(negedge Clk);
        while (sb.size() > 0) begin
            e_mon = sb.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL %s at=%0d: left unchecked", e_mon.nm, e_mon.at);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_frame_scanner.md
# vga_frame_scanner

Parametrised VGA output stage: accepts whole image frames over a Req/Ack handshake and scans them out as a pixel stream with HSync/VSync/Active timing. Each matrix element is replicated 2^SCALE_LOG2 × 2^SCALE_LOG2 on screen. Frames are held in a shadow buffer and swapped into the display buffer only at a frame boundary, giving tear-free updates. Sits at the tail of the image pipeline, after the last processing stage.

## Interface
- IMAGE_BITS, 8, bits per pixel
- MATRIX_N, 160, elements across
- MATRIX_M, 120, elements down
- SCALE_LOG2, 2, log2 of the pixel replication factor
- H_FRONT / H_SYNC / H_BACK, 16 / 96 / 48, horizontal porch and sync in clocks
- V_FRONT / V_SYNC / V_BACK, 10 / 2 / 33, vertical porch and sync in lines
- Derived: FLAT_WIDE = IMAGE_BITS*MATRIX_N*MATRIX_M; H_ACTIVE = MATRIX_N<<SCALE_LOG2; V_ACTIVE = MATRIX_M<<SCALE_LOG2; H_TOTAL and V_TOTAL are active + front + sync + back

Ports:
- Clk  in  1  pixel clock
- Reset  in  1  asynchronous, active-low
- ImgMat  in  FLAT_WIDE  input frame; element (x,y) at bits [(y*MATRIX_N+x)*IMAGE_BITS +: IMAGE_BITS]
- ReqIn  in  1  previous stage holds a valid ImgMat
- AckIn  out  1  one-cycle pulse: frame captured
- Pixel  out  IMAGE_BITS  displayed pixel, 0 outside the active area
- HSync  out  1  horizontal sync, active-low
- VSync  out  1  vertical sync, active-low
- Active  out  1  display enable
- FrameStart  out  1  one-cycle pulse coincident with pixel (0,0)
- Pending  out  1  shadow buffer holds a frame that has not yet been displayed

## Operation
- HCnt runs 0..H_TOTAL-1, then wraps. VCnt increments when HCnt wraps and itself wraps at V_TOTAL-1.
- Active region: HCnt<H_ACTIVE and VCnt<V_ACTIVE.
- HSync is low while HCnt is in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC). VSync is defined the same way on VCnt.
- Pixel = Display[(VCnt>>SCALE_LOG2)*MATRIX_N + (HCnt>>SCALE_LOG2)] when active, else 0.
- Capture: when ReqIn & ~Pending & ~AckIn:
  - Shadow <= ImgMat, Pending <= 1, AckIn <= 1 for one cycle.
  - ReqIn still high in the cycle after AckIn does not cause a second capture.
- Swap: on the last cycle of a frame (HCnt==H_TOTAL-1, VCnt==V_TOTAL-1), if Pending: Display <= Shadow, Pending <= 0.
- Simultaneous swap and ReqIn while Pending: the swap wins, and capture occurs on the following cycle.
- If ReqIn stays low, the last frame is redisplayed indefinitely.
- Reset mid-operation:
  - All outputs, counters, Shadow, Display and Pending clear immediately.
  - An in-flight ReqIn is not acknowledged until after reset is released.

## Timing
- Reset values: Pixel=0, HSync=1, VSync=1, Active=0, FrameStart=0, AckIn=0, Pending=0, HCnt=VCnt=0.
- All outputs are registered and mutually aligned. Each edge loads the outputs from the pre-edge counter values and then advances the counters.
- The first edge after reset release presents (0,0): Active=1, FrameStart=1.
- AckIn rises on the edge after ReqIn is sampled with capture conditions met (1-cycle latency).
- A captured frame is first visible at the next FrameStart after the swap. Worst case is just under 2 frames.

## Configuration
- VGA_DOUBLE_BUFFER_EN defined: Shadow and Display are separate; capture and swap behave as described in Operation.
- VGA_DOUBLE_BUFFER_EN undefined:
  - No shadow buffer, and Pending is tied to 0.
  - Capture goes directly into Display, only when VCnt>=V_ACTIVE, with ReqIn & ~AckIn.
  - ReqIn during the active region is held off until vertical blank.

## Test plan
- Idle after reset (defaults):
  - Every line: Active=1 for 640 cycles; HSync low at HCnt 656–751.
  - VSync low on lines 490–491.
  - Line period 800 cycles, FrameStart every 420000 cycles; Pixel=0 throughout.
- Capture a frame with element (x,y)=(x+y)&0xFF while ReqIn rises at VCnt=100:
  - AckIn pulses exactly once; Pending=1.
  - Current frame unchanged; swap at frame end; Pending=0.
  - Next frame shows Pixel=8 for HCnt 20–23 on lines 12–15.
- Second ReqIn while Pending: no AckIn until the cycle after the swap, then exactly one AckIn.
- ReqIn asserted exactly on the swap cycle with Pending=1: Display updates, Pending drops, and AckIn follows 2 edges later.
- Reset asserted mid-line (HCnt=300, VCnt=200): outputs go to reset values asynchronously. After release, FrameStart appears on the first edge and Pixel=0.
- Macro undefined, ReqIn at VCnt=10: no AckIn until VCnt=480. Capture then occurs, and the new frame is shown from the next FrameStart.
